// File: rtl/sd_spi_card_responder.sv
// sd_spi_card_responder
// Behaves like an SD card in SPI mode, seen from the host's side. It receives
// 48-bit command frames and sends back R1, R3 or R7 responses. It also tracks
// the idle/initialisation state of the card through CMD0, CMD55 and ACMD41.
// All SPI pins are oversampled in the clk domain.
module sd_spi_card_responder #(
  parameter int          ACMD41_POLLS = 2,
  parameter int          NCR_BYTES    = 1,
  parameter logic [31:0] OCR          = 32'h40FF8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        card_idle,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg
);

  typedef enum logic [1:0] {HUNT, CMD, NCR, RESP} state_t;

  localparam logic [6:0] NCR_LAST = 7'(NCR_BYTES * 8 - 1);
  localparam logic [7:0] POLL_MAX = 8'(ACMD41_POLLS);

  state_t      state_q;
  state_t      state_d;

  logic        sclk_s1;
  logic        sclk_s2;
  logic        sclk_d;
  logic        cs_s1;
  logic        cs_s2;
  logic        mosi_s1;
  logic        mosi_s2;
  logic        sclk_rise;
  logic        sclk_fall;

  logic [6:0]  bit_cnt;
  logic [46:0] frame;
  logic [47:0] full_frame;
  logic        frame_done;
  logic [39:0] resp_sr;
  logic [6:0]  resp_len;
  logic        miso_q;
  logic        miso_next;

  logic        idle_q;
  logic        app_q;
  logic [7:0]  poll_q;

  logic [5:0]  dec_idx;
  logic [31:0] dec_arg;
  logic        crc_ok;
  logic        dec_crc_err;
  logic        dec_illegal;
  logic        dec_idle;
  logic        dec_app;
  logic [7:0]  dec_poll;
  logic [7:0]  dec_r1;
  logic [39:0] dec_resp;
  logic [6:0]  dec_len;

  // CRC7 with generator x^7 + x^3 + 1. It is computed MSB first over the
  // start, transmission, index and argument bits.
  function automatic logic [6:0] crc7_calc(input logic [39:0] data);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // Two-flop synchronizers for the SPI pins, plus a delayed SCLK copy used for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      mosi_s1 <= 1'b1;
      mosi_s2 <= 1'b1;
    end else begin
      sclk_s1 <= spi_sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      cs_s1   <= spi_cs_n;
      cs_s2   <= cs_s1;
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sclk_rise  = sclk_s2 & ~sclk_d;
  assign sclk_fall  = ~sclk_s2 & sclk_d;
  assign full_frame = {frame, mosi_s2};
  assign frame_done = (state_q == CMD) && !cs_s2 && sclk_rise && (bit_cnt == 7'd47);
  assign dec_idx    = full_frame[45:40];
  assign dec_arg    = full_frame[39:8];
  assign crc_ok     = (crc7_calc(full_frame[47:8]) == full_frame[7:1]) && full_frame[0];

  // Work out the next card state and the response bytes for the frame that is completing
  always_comb begin
    dec_idle    = idle_q;
    dec_poll    = poll_q;
    dec_app     = 1'b0;
    dec_crc_err = 1'b0;
    dec_illegal = 1'b0;
    dec_len     = 7'd8;
    if (((dec_idx == 6'd0) || (dec_idx == 6'd8)) && !crc_ok) begin
      dec_crc_err = 1'b1;
    end else begin
      case (dec_idx)
        6'd0: begin
          dec_idle = 1'b1;
          dec_poll = 8'd0;
        end
        6'd8:  dec_len = 7'd40;
        6'd55: dec_app = 1'b1;
        6'd41: begin
          if (app_q) begin
            if (poll_q < POLL_MAX) dec_poll = poll_q + 8'd1;
            if (dec_poll == POLL_MAX) dec_idle = 1'b0;
          end else begin
            dec_illegal = 1'b1;
          end
        end
        6'd58:   dec_len = 7'd40;
        default: dec_illegal = 1'b1;
      endcase
    end
    dec_r1   = {4'b0000, dec_crc_err, dec_illegal, 1'b0, dec_idle};
    dec_resp = {dec_r1, 32'h0000_0000};
    if (!dec_crc_err) begin
      if (dec_idx == 6'd8)
        dec_resp = {dec_r1, 16'h0000, 4'h0, dec_arg[11:8], dec_arg[7:0]};
      else if (dec_idx == 6'd58)
        dec_resp = {dec_r1, ~dec_idle, OCR[30:0]};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  // Next-state logic. Deselecting the card always returns the machine to HUNT.
  always_comb begin
    state_d = state_q;
    if (cs_s2) begin
      state_d = HUNT;
    end else begin
      case (state_q)
        HUNT:    if (sclk_rise && (bit_cnt == 7'd1) && mosi_s2) state_d = CMD;
        CMD:     if (frame_done) state_d = NCR;
        NCR:     if (sclk_fall && (bit_cnt == NCR_LAST)) state_d = RESP;
        RESP:    if (sclk_fall && (bit_cnt >= resp_len)) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  // MISO value for the next falling-edge slot. It is a response bit only while bits remain, otherwise idle high.
  always_comb begin
    miso_next = 1'b1;
    if ((state_q == RESP) && (bit_cnt < resp_len)) miso_next = resp_sr[39];
  end

  // Bit counting, frame capture, response shifting and card state updates
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= 7'd0;
      frame     <= '0;
      resp_sr   <= '0;
      resp_len  <= 7'd8;
      miso_q    <= 1'b1;
      idle_q    <= 1'b1;
      app_q     <= 1'b0;
      poll_q    <= 8'd0;
      cmd_valid <= 1'b0;
      cmd_index <= 6'd0;
      cmd_arg   <= 32'd0;
    end else begin
      cmd_valid <= 1'b0;
      if (cs_s2) begin
        bit_cnt <= 7'd0;
        miso_q  <= 1'b1;
      end else begin
        if (sclk_fall) miso_q <= miso_next;
        case (state_q)
          HUNT: begin
            if (sclk_rise) begin
              frame <= full_frame[46:0];
              if (bit_cnt == 7'd0) begin
                if (!mosi_s2) bit_cnt <= 7'd1;
              end else begin
                bit_cnt <= mosi_s2 ? 7'd2 : 7'd0;
              end
            end
          end
          CMD: begin
            if (sclk_rise) begin
              frame <= full_frame[46:0];
              if (frame_done) begin
                bit_cnt   <= 7'd0;
                cmd_valid <= 1'b1;
                cmd_index <= dec_idx;
                cmd_arg   <= dec_arg;
                idle_q    <= dec_idle;
                app_q     <= dec_app;
                poll_q    <= dec_poll;
                resp_sr   <= dec_resp;
                resp_len  <= dec_len;
              end else begin
                bit_cnt <= bit_cnt + 7'd1;
              end
            end
          end
          NCR: begin
            if (sclk_fall) bit_cnt <= (bit_cnt == NCR_LAST) ? 7'd0 : bit_cnt + 7'd1;
          end
          RESP: begin
            if (sclk_fall) begin
              if (bit_cnt < resp_len) begin
                resp_sr <= {resp_sr[38:0], 1'b0};
                bit_cnt <= bit_cnt + 7'd1;
              end else begin
                bit_cnt <= 7'd0;
              end
            end
          end
          default: bit_cnt <= 7'd0;
        endcase
      end
    end
  end

  assign card_idle = idle_q;
  assign spi_miso  = miso_q | spi_cs_n;

endmodule

// File: doc/sd_spi_card_responder.md
SD_SPI_CARD_RESPONDER -- requirements
Module: sd_spi_card_responder

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all ports SHALL be as listed below.
REQ-002 Parameter ACMD41_POLLS, default 2, SHALL set the number of ACMD41 commands needed to leave idle (range 1..255).
REQ-003 Parameter NCR_BYTES, default 1, SHALL set the number of 0xFF filler bytes sent before every response (range 1..8).
REQ-004 Parameter OCR, default 32'h40FF8000, SHALL be the OCR value; bit 31 is overridden by the power-up status.
REQ-005 Ports: clk in 1 system clock; rst in 1 sync active-high reset; spi_sclk in 1 host SPI clock; spi_cs_n in 1 chip select, active-low; spi_mosi in 1 host-to-card data; spi_miso out 1 card-to-host data.
REQ-006 Ports: card_idle out 1 R1 idle flag; cmd_valid out 1 one-cycle pulse per accepted frame; cmd_index out 6 last command index; cmd_arg out 32 last argument.

Function
REQ-007 spi_sclk, spi_cs_n and spi_mosi SHALL pass through 2-flop synchronizers; spi_sclk edges SHALL be detected in the clk domain; spi_sclk <= clk/4 is supported.
REQ-008 MOSI SHALL be sampled on synchronized SCLK rising edges; MISO SHALL change only on synchronized SCLK falling edges, MSB first.
REQ-009 FSM states: HUNT, CMD, NCR, RESP.
REQ-010 HUNT: first sampled 0 SHALL be the start bit; the next bit SHALL be 1 (transmission bit) or HUNT restarts; on 1 -> CMD.
REQ-011 CMD: the remaining 46 bits SHALL be shifted into a 48-bit frame register; after bit 48, frame decoded, cmd_valid pulses once, cmd_index/cmd_arg update -> NCR.
REQ-012 NCR: NCR_BYTES x 8 bits of 1 SHALL be driven -> RESP.
REQ-013 RESP: response bytes SHALL be driven MSB first; after the last bit's falling-edge slot ends -> HUNT; MOSI ignored during NCR and RESP.
REQ-014 MISO SHALL be 1 in HUNT, CMD and NCR, and whenever spi_cs_n is high.
REQ-015 spi_cs_n high in any state SHALL abort to HUNT within 3 clk cycles, clearing bit counters; card state is kept.
REQ-016 CRC7 (poly x^7+x^3+1, over the first 40 bits) SHALL be checked for CMD0 and CMD8 only; mismatch or end bit 0 -> R1 = 0x08|idle, no state change.
REQ-017 R1 = {0, 0, 0, 0, crc_err, illegal, 0, idle}.
REQ-018 CMD0: idle=1, poll count=0, app_cmd=0; R1 only.
REQ-019 CMD8: R7 = R1, 0x00, 0x00, {4'h0, arg[11:8]}, arg[7:0] (5 bytes).
REQ-020 CMD55: app_cmd=1; R1.
REQ-021 Index 41 with app_cmd=1: poll count saturates at ACMD41_POLLS; when reached, idle=0; R1 SHALL reflect idle after the update.
REQ-022 CMD58: R3 = R1, then {~idle, OCR[30:0]} MSB first (5 bytes).
REQ-023 Any other index, or 41 without app_cmd: R1 with illegal=1; no state change.
REQ-024 app_cmd SHALL clear after every decoded frame other than CMD55.
REQ-025 card_idle SHALL equal the internal idle flag.

Reset
REQ-026 On rst: FSM=HUNT, spi_miso=1, card_idle=1, cmd_valid=0, cmd_index=0, cmd_arg=0, app_cmd=0, poll count=0, synchronizers=idle (sclk 0, cs_n 1, mosi 1).
REQ-027 rst asserted mid-frame or mid-response SHALL take priority; the next frame after rst is decoded normally.

Verification
REQ-028 CMD0 40 00 00 00 00 95 -> 1 byte FF, then 01; cmd_valid once, cmd_index=0.
REQ-029 CMD8 48 00 00 01 AA 87 -> FF, then 01 00 00 01 AA.
REQ-030 CMD55 then ACMD41 69 40 00 00 00 xx, twice -> first 01, second 00; card_idle 1->0; CMD58 then returns 00 C0 FF 80 00.
REQ-031 CMD0 with CRC 94 -> 09; ACMD41 without a preceding CMD55 -> 05; card_idle unchanged.
REQ-032 cs_n high after 20 CMD bits, then full CMD0 -> abort (MISO=1, no cmd_valid), then 01; rst during RESP -> MISO=1, card_idle=1 next cycle.
